// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a length-prefixed little-endian word stream into instruction memory, holding the CPU in reset until done.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before release.
module inst_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        HDR0, HDR1, DATA, WRITE, DONE, ERR
`ifdef LOADER_CHECKSUM_EN
        , CKSUM
`endif
    } state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CKSUM;
    logic [7:0] csum;
`else
    localparam state_t FIN = DONE;
`endif
    state_t state, state_n;
    logic live, acc;
    logic [15:0] count;
    logic [ADDR_W:0] word_idx;
    logic [1:0] byte_idx;
    logic [31:0] word;
    logic [16:0] hdr;
    assign hdr = {1'b0, in_data, count[7:0]};
    assign mem_we = state == WRITE;
    assign mem_addr = word_idx[ADDR_W-1:0];
    assign mem_wdata = word;
    assign cpu_hold = state != DONE;
    assign done = state == DONE;
    assign err = state == ERR;
    // live keeps in_ready low during the first cycle after reset release
    always_comb begin
        in_ready = live && state != WRITE && state != DONE && state != ERR;
        acc = in_valid && in_ready;
        state_n = state;
        case (state)
            HDR0:  if (acc) state_n = HDR1;
            HDR1:  if (acc) state_n = hdr == 17'd0 ? FIN : hdr > (17'd1 << ADDR_W) ? ERR : DATA;
            DATA:  if (acc && byte_idx == 2'd3) state_n = WRITE;
            WRITE: state_n = 17'(word_idx) + 17'd1 == {1'b0, count} ? FIN : DATA;
            DONE:  if (start) state_n = HDR0;
`ifdef LOADER_CHECKSUM_EN
            CKSUM: if (acc) state_n = in_data == csum ? DONE : ERR;
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HDR0;
            live <= 1'b0;
            count <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            state <= state_n;
            live <= 1'b1;
            if (state == HDR0 && acc) count[7:0] <= in_data;
            if (state == HDR1 && acc) begin
                count[15:8] <= in_data;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (state == DATA && acc) begin
                word[{byte_idx, 3'b000} +: 8] <= in_data;
                byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ in_data;
`endif
            end
            if (state == WRITE) word_idx <= word_idx + 1'b1;
            if (state == DONE && start) begin
                count <= '0;
                word_idx <= '0;
                byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
        end
    end
endmodule
